// File: rtl/gpio_irq_pkg.sv
// Shared types and constants for the GPIO interrupt generator.
package gpio_irq_pkg;

  localparam int unsigned IrqTypeWidth = 3;

  // Codes 5-7 are reserved and never produce an event.
  typedef enum logic [IrqTypeWidth-1:0] {
    IrqRise = 3'd0,
    IrqFall = 3'd1,
    IrqBoth = 3'd2,
    IrqHigh = 3'd3,
    IrqLow  = 3'd4
  } gpio_irq_type_e;

endpackage

// File: rtl/gpio_irq_pin.sv
// Per-pin interrupt event decode and pending bit.
module gpio_irq_pin
  import gpio_irq_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    serial_i,
  input  logic                    r_edge_i,
  input  logic                    f_edge_i,
  input  logic                    irq_en_i,
  input  logic [IrqTypeWidth-1:0] irq_type_i,
  input  logic                    status_clr_i,
  output logic                    status_o,
  output logic                    rise_o
);

  logic evt;
  logic set;
  logic status_d, status_q;

  // Decode the configured event type from the input-stage signals.
  always_comb begin
    evt = 1'b0;
    case (irq_type_i)
      IrqRise: evt = r_edge_i;
      IrqFall: evt = f_edge_i;
      IrqBoth: evt = r_edge_i | f_edge_i;
      IrqHigh: evt = serial_i;
      IrqLow:  evt = ~serial_i;
      default: evt = 1'b0;
    endcase
  end

  // Next pending state: set wins over write-1-to-clear; the enable gates sets only.
  always_comb begin
    set      = evt & irq_en_i;
    status_d = set | (status_q & ~status_clr_i);
    rise_o   = set & ~status_q;
  end

  // Pending bit register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= 1'b0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/gpio_irq_gen.sv
// GPIO interrupt generator: per-pin pending bits, level IRQ and new-pending pulse.
module gpio_irq_gen
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NrGPIOs = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrGPIOs-1:0]                   serial_i,
  input  logic [NrGPIOs-1:0]                   r_edge_i,
  input  logic [NrGPIOs-1:0]                   f_edge_i,
  input  logic [NrGPIOs-1:0]                   irq_en_i,
  input  logic [NrGPIOs-1:0][IrqTypeWidth-1:0] irq_type_i,
  input  logic [NrGPIOs-1:0]                   status_clr_i,
  output logic [NrGPIOs-1:0]                   status_o,
  output logic                                 irq_o,
  output logic                                 irq_pulse_o
);

  logic [NrGPIOs-1:0] rise;
  logic               pulse_d, pulse_q;

  for (genvar i = 0; i < NrGPIOs; i++) begin : g_pin
    gpio_irq_pin u_pin (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .serial_i     (serial_i[i]),
      .r_edge_i     (r_edge_i[i]),
      .f_edge_i     (f_edge_i[i]),
      .irq_en_i     (irq_en_i[i]),
      .irq_type_i   (irq_type_i[i]),
      .status_clr_i (status_clr_i[i]),
      .status_o     (status_o[i]),
      .rise_o       (rise[i])
    );
  end

  // Any bit about to go 0->1 yields one pulse, aligned with its appearance on status_o.
  always_comb begin
    pulse_d = |rise;
    irq_o   = |status_o;
  end

  // Pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign irq_pulse_o = pulse_q;

endmodule

// File: tb/tb_gpio_irq_gen.sv
// Self-checking bench for gpio_irq_gen: per-cycle scoreboard plus directed scenarios.
module tb_gpio_irq_gen;

  localparam int N = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      serial_i, r_edge_i, f_edge_i, irq_en_i, status_clr_i;
  logic [N-1:0][2:0] irq_type_i;
  logic [N-1:0]      status_o;
  logic              irq_o, irq_pulse_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] st;
    logic         irq;
    logic         pulse;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] m_st;

  gpio_irq_gen #(
    .NrGPIOs (N)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .serial_i     (serial_i),
    .r_edge_i     (r_edge_i),
    .f_edge_i     (f_edge_i),
    .irq_en_i     (irq_en_i),
    .irq_type_i   (irq_type_i),
    .status_clr_i (status_clr_i),
    .status_o     (status_o),
    .irq_o        (irq_o),
    .irq_pulse_o  (irq_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_evt(input int i);
    case (irq_type_i[i])
      3'd0:    return r_edge_i[i];
      3'd1:    return f_edge_i[i];
      3'd2:    return r_edge_i[i] | f_edge_i[i];
      3'd3:    return serial_i[i];
      3'd4:    return !serial_i[i];
      default: return 1'b0;
    endcase
  endfunction

  // Predict the next state from the driven inputs, clock once, compare, drop strobes.
  task automatic tick(input string tag);
    logic [N-1:0] nxt;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      if (model_evt(i) && irq_en_i[i]) nxt[i] = 1'b1;
      else if (status_clr_i[i])        nxt[i] = 1'b0;
      else                             nxt[i] = m_st[i];
    end
    e.st    = nxt;
    e.irq   = (nxt != '0);
    e.pulse = ((nxt & ~m_st) != '0);
    m_st    = nxt;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, "_status"}, status_o, e.st);
    check_eq({tag, "_irq"}, irq_o, e.irq);
    check_eq({tag, "_pulse"}, irq_pulse_o, e.pulse);
    r_edge_i     = '0;
    f_edge_i     = '0;
    status_clr_i = '0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    serial_i     = '0;
    r_edge_i     = '0;
    f_edge_i     = '0;
    irq_en_i     = '0;
    status_clr_i = '0;
    irq_type_i   = '0;
    m_st         = '0;
    #12;
    check_eq("reset_status", status_o, 0);
    check_eq("reset_irq", irq_o, 0);
    check_eq("reset_pulse", irq_pulse_o, 0);
    rst_ni   = 1'b1;
    irq_en_i = 32'h0000_00FF;

    // Rising edge on pin 0 at cycle 10.
    for (int c = 0; c < 10; c++) tick("idle");
    r_edge_i[0] = 1'b1;
    tick("rise0");
    check_eq("rise0_bit", status_o[0], 1);
    check_eq("rise0_irq", irq_o, 1);
    check_eq("rise0_pulse", irq_pulse_o, 1);
    tick("rise0_hold");
    check_eq("rise0_pulse_once", irq_pulse_o, 0);
    status_clr_i[0] = 1'b1;
    tick("clr0");

    // HIGH level on pin 3 survives clears until the level drops.
    irq_type_i[3] = 3'd3;
    serial_i[3]   = 1'b1;
    tick("high3");
    status_clr_i[3] = 1'b1;
    tick("high3_clr");
    check_eq("high3_kept", status_o[3], 1);
    check_eq("high3_no_pulse", irq_pulse_o, 0);
    serial_i[3] = 1'b0;
    tick("high3_low");
    status_clr_i[3] = 1'b1;
    tick("high3_clr2");
    check_eq("high3_cleared", status_o[3], 0);
    check_eq("high3_irq_off", irq_o, 0);

    // FALL on pin 5: set and clear together while pending.
    irq_type_i[5] = 3'd1;
    f_edge_i[5]   = 1'b1;
    tick("fall5");
    f_edge_i[5]     = 1'b1;
    status_clr_i[5] = 1'b1;
    tick("fall5_setclr");
    check_eq("fall5_kept", status_o[5], 1);
    check_eq("fall5_no_pulse", irq_pulse_o, 0);
    status_clr_i[5] = 1'b1;
    tick("fall5_clr");

    // BOTH on pins 1 and 2 together, then pin 7 a cycle later.
    irq_type_i[1] = 3'd2;
    irq_type_i[2] = 3'd2;
    irq_type_i[7] = 3'd2;
    r_edge_i[1]   = 1'b1;
    f_edge_i[2]   = 1'b1;
    tick("both12");
    check_eq("both12_status", status_o, 32'h6);
    check_eq("both12_pulse", irq_pulse_o, 1);
    r_edge_i[7] = 1'b1;
    tick("both7");
    check_eq("both7_pulse", irq_pulse_o, 1);
    tick("both_idle");
    check_eq("both_idle_pulse", irq_pulse_o, 0);
    status_clr_i = '1;
    tick("clr_all");

    // Pin 4: disabled, reserved type, retained when disabled while pending.
    irq_en_i[4] = 1'b0;
    r_edge_i[4] = 1'b1;
    tick("dis4");
    check_eq("dis4_bit", status_o[4], 0);
    irq_en_i[4]   = 1'b1;
    irq_type_i[4] = 3'd6;
    r_edge_i[4]   = 1'b1;
    f_edge_i[4]   = 1'b1;
    serial_i[4]   = 1'b1;
    tick("rsv4_hi");
    serial_i[4] = 1'b0;
    tick("rsv4_lo");
    check_eq("rsv4_bit", status_o[4], 0);
    irq_type_i[4] = 3'd0;
    r_edge_i[4]   = 1'b1;
    tick("set4");
    irq_en_i[4]   = 1'b0;
    irq_type_i[4] = 3'd3;
    tick("keep4");
    check_eq("keep4_bit", status_o[4], 1);
    irq_type_i[4] = 3'd0;
    irq_en_i[4]   = 1'b1;
    status_clr_i  = '1;
    tick("clr_all2");

    // Randomised traffic against the scoreboard.
    for (int c = 0; c < 60; c++) begin
      serial_i     = $urandom;
      r_edge_i     = $urandom & $urandom;
      f_edge_i     = $urandom & $urandom;
      irq_en_i     = $urandom | $urandom;
      status_clr_i = $urandom & $urandom;
      for (int i = 0; i < N; i++) irq_type_i[i] = 3'($urandom_range(0, 7));
      tick("rand");
    end
    serial_i   = '0;
    irq_type_i = '0;
    irq_en_i   = 32'h0000_00FF;
    status_clr_i = '1;
    tick("clr_all3");

    // Reset mid-cycle with eight bits pending.
    r_edge_i = 32'h0000_00FF;
    tick("set_ff");
    check_eq("set_ff_status", status_o, 32'hFF);
    #4;
    rst_ni = 1'b0;
    #1;
    check_eq("rst_async_status", status_o, 0);
    check_eq("rst_async_irq", irq_o, 0);
    check_eq("rst_async_pulse", irq_pulse_o, 0);
    m_st = '0;
    sb_q.delete();
    @(posedge clk_i);
    #1;
    check_eq("rst_hold_status", status_o, 0);
    rst_ni      = 1'b1;
    r_edge_i[0] = 1'b1;
    tick("post_rst");
    check_eq("post_rst_pulse", irq_pulse_o, 1);
    check_eq("post_rst_status", status_o, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_irq_gen.md
GPIO_IRQ_GEN -- requirements
Module: gpio_irq_gen

Interface
REQ-001 SHALL have parameter NrGPIOs, default 32, number of GPIO channels handled.
REQ-002 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port serial_i  input  NrGPIOs  synchronized pin level, one bit per GPIO, from the per-pin input stage.
REQ-005 SHALL have port r_edge_i  input  NrGPIOs  one-cycle rising-edge strobe per GPIO, from the input stage.
REQ-006 SHALL have port f_edge_i  input  NrGPIOs  one-cycle falling-edge strobe per GPIO, from the input stage.
REQ-007 SHALL have port irq_en_i  input  NrGPIOs  per-GPIO interrupt enable.
REQ-008 SHALL have port irq_type_i  input  NrGPIOs x 3  per-GPIO interrupt type, encoded as gpio_irq_type_e.
REQ-009 SHALL have port status_clr_i  input  NrGPIOs  write-1-to-clear strobe for the pending bits.
REQ-010 SHALL have port status_o  output  NrGPIOs  registered pending bits.
REQ-011 SHALL have port irq_o  output  1  level interrupt, OR of all pending bits.
REQ-012 SHALL have port irq_pulse_o  output  1  one-cycle pulse whenever at least one pending bit goes 0->1.

Function
REQ-013 Type encoding SHALL be: 0 RISE, 1 FALL, 2 BOTH (rise or fall), 3 HIGH (serial_i==1), 4 LOW (serial_i==0); codes 5-7 are reserved and produce no event.
REQ-014 Event for pin i SHALL be computed combinationally from r_edge_i/f_edge_i/serial_i and irq_type_i in the same cycle.
REQ-015 Pending bit i SHALL be set on the next clock edge when the event is active and irq_en_i[i]==1; latency from input strobe to status_o is one cycle.
REQ-016 Pending bit i SHALL be cleared on the next clock edge when status_clr_i[i]==1 and no set occurs for it in that cycle.
REQ-017 On simultaneous set and clear of the same bit, set SHALL win (bit stays or becomes 1).
REQ-018 Level types SHALL re-set the bit every cycle the level holds, so clearing while the level persists leaves the bit at 1.
REQ-019 Deasserting irq_en_i[i] SHALL block new sets only; an already pending bit SHALL be kept until cleared.
REQ-020 Changing irq_type_i while a bit is pending SHALL neither set nor clear it.
REQ-021 irq_o SHALL be the combinational OR of the status registers, so it asserts in the same cycle as status_o.
REQ-022 irq_pulse_o SHALL be registered: high for exactly one cycle, the same cycle the new bit appears on status_o, when any bit goes 0->1.
REQ-023 Several bits rising in the same cycle SHALL produce one pulse; bits rising in consecutive cycles SHALL produce consecutive pulses.
REQ-024 Bits that stay 1 because of repeated level sets SHALL NOT produce further pulses.

Reset
REQ-025 While rst_ni==0, status_o SHALL be all 0, irq_o 0 and irq_pulse_o 0, independent of clk_i.
REQ-026 Reset asserted while bits are pending SHALL discard them; the first set after reset release SHALL produce a pulse.

Structure
REQ-027 Package gpio_irq_pkg SHALL hold the gpio_irq_type_e enum (3 bit) and its width constant.
REQ-028 The per-pin event decode and pending register SHALL be one sub-module, gpio_irq_pin, instantiated NrGPIOs times.
REQ-029 The OR reduction and the pulse register SHALL live in gpio_irq_gen.

Verification
REQ-030 Pin 0: type RISE, en=1, r_edge_i[0] pulse at cycle 10 -> status_o[0]=1 and irq_o=1 at cycle 11, irq_pulse_o=1 for cycle 11 only.
REQ-031 Pin 3: type HIGH, serial_i[3]=1 held, status_clr_i[3] pulsed -> status_o[3] stays 1; after serial_i[3]=0, one clear pulse -> status_o[3]=0 the next cycle, irq_o=0.
REQ-032 Pin 5: type FALL, f_edge_i[5] and status_clr_i[5] in the same cycle while already pending -> status_o[5]=1; no new pulse.
REQ-033 Pins 1 and 2: type BOTH, edges in the same cycle -> status_o=0x6 and a single irq_pulse_o; a third edge on pin 7 one cycle later -> second pulse.
REQ-034 Pin 4: en=0, r_edge_i[4] -> no set; type code 6 with any stimulus -> no set; pending pin 4 then en=0 -> bit retained.
REQ-035 status_o=0xFF, rst_ni driven low mid-cycle -> all outputs 0 immediately; after release, first RISE event -> pulse.
